// File: rtl/blank_arb_pkg.sv
// Shared definitions for the vertical-blank update arbiter: FSM state
// encodings, default sizing parameters and the served-counter width.
package blank_arb_pkg;

    localparam int DEFAULT_N_REQ    = 4;
    localparam int DEFAULT_MAX_HOLD = 16;
    localparam int SERVED_W         = 8;

    localparam logic [SERVED_W-1:0] SERVED_MAX = '1;

    // Arbiter FSM state type and its legacy-compatible encodings
    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE  = 2'd0;
    localparam arb_state_t ST_ARB   = 2'd1;
    localparam arb_state_t ST_GRANT = 2'd2;
    localparam arb_state_t ST_DRAIN = 2'd3;

endpackage

// File: rtl/blank_arbiter_rr_picker.sv
// Combinational round-robin selector: scans the request vector starting
// one position after the pointer, wrapping at N_REQ-1, and returns a
// one-hot grant for the first set bit plus a valid flag.
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic             valid
);

    logic [PTR_W-1:0] pos;

    // First requester after the pointer wins; later hits are masked by valid
    always_comb begin
        grant = '0;
        valid = 1'b0;
        pos   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            pos = PTR_W'((int'(ptr) + k) % N_REQ);
            if (!valid && req[pos]) begin
                grant[pos] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/blank_arbiter.sv
// Vertical-blank arbiter: opens an update window on the animation tick,
// hands the shared game-state port to one requester at a time in
// round-robin order and closes the window at end of screen.
// Optional feature macro: BLANK_ARB_TIMEOUT_EN (grant hold limit of
// MAX_HOLD cycles with a one-cycle out_timeout pulse on force-release).
module blank_arbiter
    import blank_arb_pkg::*;
#(
    parameter int N_REQ    = DEFAULT_N_REQ,
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
    input  logic                in_clock,
    input  logic                in_reset_n,
    input  logic                in_strobe,
    input  logic                in_anim,
    input  logic                in_scrend,
    input  logic [N_REQ-1:0]    in_req,
    input  logic [N_REQ-1:0]    in_done,
    output logic [N_REQ-1:0]    out_grant,
    output logic                out_window,
    output logic                out_overrun,
    output logic [SERVED_W-1:0] out_served
`ifdef BLANK_ARB_TIMEOUT_EN
    ,
    output logic                out_timeout
`endif
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_t       state;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] grant_idx;
    logic [PTR_W-1:0] win_idx;
    logic [N_REQ-1:0] pick_grant;
    logic             pick_valid;
    logic             released;
    logic             scr_close;
    logic             others_pending;

`ifdef BLANK_ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    logic [HOLD_W-1:0] hold_cnt;
    logic              hold_expired;
`endif

    rr_picker #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req   (in_req),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .valid (pick_valid)
    );

    // Binary index of the picker's one-hot winner, used for the pointer
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_grant[i]) begin
                win_idx = PTR_W'(i);
            end
        end
    end

    // Release, window-close and pending-request conditions for this cycle
    always_comb begin
        released       = (state == ST_GRANT) &&
                         (in_done[grant_idx] || !in_req[grant_idx]);
        scr_close      = in_strobe && in_scrend &&
                         ((state == ST_ARB) || (state == ST_GRANT));
        others_pending = |(in_req & ~out_grant);
    end

`ifdef BLANK_ARB_TIMEOUT_EN
    // Hold limit reached on the last allowed cycle of an unreleased grant
    always_comb begin
        hold_expired = (state == ST_GRANT) && !released &&
                       (hold_cnt == HOLD_W'(MAX_HOLD - 1));
    end
`endif

    // Main FSM: window control, grant issue/release and the status outputs
    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state       <= ST_IDLE;
            out_grant   <= '0;
            out_window  <= 1'b0;
            out_overrun <= 1'b0;
            out_served  <= '0;
            rr_ptr      <= PTR_W'(N_REQ - 1);
            grant_idx   <= '0;
`ifdef BLANK_ARB_TIMEOUT_EN
            hold_cnt    <= '0;
            out_timeout <= 1'b0;
`endif
        end else begin
`ifdef BLANK_ARB_TIMEOUT_EN
            out_timeout <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (in_strobe && in_anim) begin
                        state      <= ST_ARB;
                        out_window <= 1'b1;
                        out_served <= '0;
                    end
                end

                ST_ARB: begin
                    if (scr_close) begin
                        state      <= ST_DRAIN;
                        out_window <= 1'b0;
                        if (|in_req) begin
                            out_overrun <= 1'b1;
                        end
                    end else if (pick_valid) begin
                        state     <= ST_GRANT;
                        out_grant <= pick_grant;
                        grant_idx <= win_idx;
                        rr_ptr    <= win_idx;
`ifdef BLANK_ARB_TIMEOUT_EN
                        hold_cnt  <= '0;
`endif
                    end
                end

                ST_GRANT: begin
                    if (scr_close) begin
                        state      <= ST_DRAIN;
                        out_window <= 1'b0;
                        out_grant  <= '0;
                        if (released) begin
                            if (out_served != SERVED_MAX) begin
                                out_served <= out_served + 1'b1;
                            end
                            if (others_pending) begin
                                out_overrun <= 1'b1;
                            end
                        end else begin
                            out_overrun <= 1'b1;
                        end
                    end else if (released) begin
                        state     <= ST_ARB;
                        out_grant <= '0;
                        if (out_served != SERVED_MAX) begin
                            out_served <= out_served + 1'b1;
                        end
`ifdef BLANK_ARB_TIMEOUT_EN
                    end else if (hold_expired) begin
                        state       <= ST_ARB;
                        out_grant   <= '0;
                        out_timeout <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
`endif
                    end
                end

                ST_DRAIN: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state     <= ST_IDLE;
                    out_grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_blank_arbiter.sv
// Directed self-checking bench for blank_arbiter with hand-computed
// expected values for grant order, window timing, overrun and served count.
module tb_blank_arbiter;

    localparam int N_REQ = 4;

    logic             in_clock = 1'b0;
    logic             in_reset_n;
    logic             in_strobe;
    logic             in_anim;
    logic             in_scrend;
    logic [N_REQ-1:0] in_req;
    logic [N_REQ-1:0] in_done;
    logic [N_REQ-1:0] out_grant;
    logic             out_window;
    logic             out_overrun;
    logic [7:0]       out_served;
`ifdef BLANK_ARB_TIMEOUT_EN
    logic             out_timeout;
`endif

    int checks = 0;
    int errors = 0;

    blank_arbiter #(
        .N_REQ    (N_REQ),
        .MAX_HOLD (16)
    ) dut (
        .in_clock    (in_clock),
        .in_reset_n  (in_reset_n),
        .in_strobe   (in_strobe),
        .in_anim     (in_anim),
        .in_scrend   (in_scrend),
        .in_req      (in_req),
        .in_done     (in_done),
        .out_grant   (out_grant),
        .out_window  (out_window),
        .out_overrun (out_overrun),
        .out_served  (out_served)
`ifdef BLANK_ARB_TIMEOUT_EN
        ,
        .out_timeout (out_timeout)
`endif
    );

    always #5 in_clock = ~in_clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, clock it in, then sample 1 ns after the edge
    task automatic applyStimulus(input logic [3:0] req, input logic [3:0] done,
                                 input logic anim, input logic scrend);
        in_req    = req;
        in_done   = done;
        in_anim   = anim;
        in_scrend = scrend;
        @(posedge in_clock);
        #1;
        in_anim   = 1'b0;
        in_scrend = 1'b0;
        in_done   = 4'b0000;
    endtask

    initial begin
        in_reset_n = 1'b0;
        in_strobe  = 1'b1;
        in_anim    = 1'b0;
        in_scrend  = 1'b0;
        in_req     = 4'b0000;
        in_done    = 4'b0000;
        repeat (3) @(posedge in_clock);
        #1;
        checkOutput("reset_grant",   32'(out_grant),   32'h0);
        checkOutput("reset_window",  32'(out_window),  32'h0);
        checkOutput("reset_overrun", 32'(out_overrun), 32'h0);
        checkOutput("reset_served",  32'(out_served),  32'h0);
        in_reset_n = 1'b1;

        // Anim tick without strobe and end-of-screen in IDLE are both ignored
        in_strobe = 1'b0;
        applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b0);
        checkOutput("no_strobe_window", 32'(out_window), 32'h0);
        in_strobe = 1'b1;
        applyStimulus(4'b1111, 4'b0000, 1'b0, 1'b1);
        checkOutput("idle_scrend_window",  32'(out_window),  32'h0);
        checkOutput("idle_scrend_overrun", 32'(out_overrun), 32'h0);

        // Window opens; all four request, granted 0,1,2,3 in order
        applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b0);
        checkOutput("open_window", 32'(out_window), 32'h1);
        checkOutput("open_grant",  32'(out_grant),  32'h0);
        applyStimulus(4'b1111, 4'b0000, 1'b0, 1'b0);
        checkOutput("rr_grant_0", 32'(out_grant), 32'h1);
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                applyStimulus(4'b1111, 4'b0100, 1'b0, 1'b0);
                checkOutput("foreign_done_grant", 32'(out_grant), 32'h2);
            end
            applyStimulus(4'b1111, 4'(1 << i), 1'b0, 1'b0);
            checkOutput("release_gap", 32'(out_grant), 32'h0);
            checkOutput("release_served", 32'(out_served), 32'(i + 1));
            applyStimulus(4'b1111, 4'b0000, 1'b0, 1'b0);
            checkOutput("rr_grant_next", 32'(out_grant), 32'(1 << (i + 1)));
        end
        applyStimulus(4'b1111, 4'b1000, 1'b0, 1'b0);
        checkOutput("served_four", 32'(out_served), 32'h4);

        // Last grant was 3, only requester 2 asks: granted after one gap cycle
        applyStimulus(4'b0100, 4'b0000, 1'b0, 1'b0);
        checkOutput("single_req_grant", 32'(out_grant), 32'h4);

        // Withdrawal releases the grant and counts as served
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
        checkOutput("withdraw_grant",  32'(out_grant),  32'h0);
        checkOutput("withdraw_served", 32'(out_served), 32'h5);
        applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0);
        checkOutput("anim_in_arb_window", 32'(out_window), 32'h1);
        checkOutput("empty_arb_grant",    32'(out_grant),  32'h0);

        // Grant held at 1 when the screen ends: revoked, overrun raised
        applyStimulus(4'b0010, 4'b0000, 1'b0, 1'b0);
        checkOutput("grant_one", 32'(out_grant), 32'h2);
        applyStimulus(4'b0010, 4'b0000, 1'b0, 1'b1);
        checkOutput("close_grant",   32'(out_grant),   32'h0);
        checkOutput("close_window",  32'(out_window),  32'h0);
        checkOutput("close_overrun", 32'(out_overrun), 32'h1);
        checkOutput("close_served",  32'(out_served),  32'h5);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0);
        checkOutput("frame2_window",  32'(out_window),  32'h1);
        checkOutput("frame2_served",  32'(out_served),  32'h0);
        checkOutput("frame2_overrun", 32'(out_overrun), 32'h1);

        // Reset mid-grant clears everything without waiting for a clock edge
        applyStimulus(4'b0001, 4'b0000, 1'b0, 1'b0);
        checkOutput("pre_reset_grant", 32'(out_grant), 32'h1);
        #2;
        in_reset_n = 1'b0;
        #1;
        checkOutput("async_reset_grant",   32'(out_grant),   32'h0);
        checkOutput("async_reset_window",  32'(out_window),  32'h0);
        checkOutput("async_reset_overrun", 32'(out_overrun), 32'h0);
        @(posedge in_clock);
        #1;
        in_reset_n = 1'b1;
        applyStimulus(4'b1111, 4'b0000, 1'b0, 1'b0);
        applyStimulus(4'b1111, 4'b0000, 1'b0, 1'b0);
        checkOutput("post_reset_no_grant",  32'(out_grant),  32'h0);
        checkOutput("post_reset_no_window", 32'(out_window), 32'h0);

        // Simultaneous release and end-of-screen: served, no overrun
        applyStimulus(4'b0001, 4'b0000, 1'b1, 1'b0);
        applyStimulus(4'b0001, 4'b0000, 1'b0, 1'b0);
        checkOutput("post_reset_first_grant", 32'(out_grant), 32'h1);
        applyStimulus(4'b0001, 4'b0001, 1'b0, 1'b1);
        checkOutput("done_close_served",  32'(out_served),  32'h1);
        checkOutput("done_close_overrun", 32'(out_overrun), 32'h0);
        checkOutput("done_close_window",  32'(out_window),  32'h0);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);

        // Empty window close raises no overrun
        applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0);
        checkOutput("frame3_served", 32'(out_served), 32'h0);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b1);
        checkOutput("empty_close_overrun", 32'(out_overrun), 32'h0);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);

        // Served counter saturates at 255
        applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0);
        for (int n = 0; n < 260; n++) begin
            applyStimulus(4'b0001, 4'b0000, 1'b0, 1'b0);
            applyStimulus(4'b0001, 4'b0001, 1'b0, 1'b0);
        end
        checkOutput("served_saturate", 32'(out_served), 32'hFF);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b1);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);

`ifdef BLANK_ARB_TIMEOUT_EN
        // Unreleased grant is force-released after 16 cycles
        in_reset_n = 1'b0;
        #1;
        in_reset_n = 1'b1;
        applyStimulus(4'b0011, 4'b0000, 1'b1, 1'b0);
        applyStimulus(4'b0011, 4'b0000, 1'b0, 1'b0);
        checkOutput("to_grant0", 32'(out_grant), 32'h1);
        repeat (15) applyStimulus(4'b0011, 4'b0000, 1'b0, 1'b0);
        checkOutput("to_still_held", 32'(out_grant),   32'h1);
        checkOutput("to_no_pulse",   32'(out_timeout), 32'h0);
        applyStimulus(4'b0011, 4'b0000, 1'b0, 1'b0);
        checkOutput("to_release", 32'(out_grant),   32'h0);
        checkOutput("to_pulse",   32'(out_timeout), 32'h1);
        checkOutput("to_served",  32'(out_served),  32'h0);
        applyStimulus(4'b0011, 4'b0000, 1'b0, 1'b0);
        checkOutput("to_pulse_end", 32'(out_timeout), 32'h0);
        checkOutput("to_next_grant", 32'(out_grant),  32'h2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/blank_arbiter.md
BLANK_ARBITER -- requirements
Module: blank_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the game-state update port.
REQ-002 Parameter MAX_HOLD, default 16, maximum clock cycles one grant may be held (used only under REQ-031).
REQ-003 in_clock  input  1  system clock; all state changes on its rising edge.
REQ-004 in_reset_n  input  1  asynchronous, active-low reset.
REQ-005 in_strobe  input  1  pixel-clock enable from the VGA timing generator.
REQ-006 in_anim  input  1  animation tick (end of last active line); sampled only when in_strobe=1.
REQ-007 in_scrend  input  1  end-of-screen tick; sampled only when in_strobe=1.
REQ-008 in_req  input  N_REQ  per-requester level request for the shared update port.
REQ-009 in_done  input  N_REQ  per-requester release pulse; honoured only from the currently granted requester.
REQ-010 out_grant  output  N_REQ  one-hot or zero grant vector.
REQ-011 out_window  output  1  high while the vertical-blank update window is open.
REQ-012 out_overrun  output  1  sticky: window closed while a request was pending or granted.
REQ-013 out_served  output  8  grants completed in the current window, saturating at 255.

Function
REQ-014 FSM states: IDLE, ARB, GRANT, DRAIN.
REQ-015 IDLE->ARB when in_strobe&in_anim; out_window goes high in the same edge.
REQ-016 ARB: if any in_req bit is set, the round-robin winner is granted on the next edge (state GRANT); otherwise the FSM stays in ARB.
REQ-017 Round-robin: search starts at the index after the last granted requester, wrapping N_REQ-1->0; the pointer persists across frames and resets to N_REQ-1, so requester 0 wins first.
REQ-018 GRANT: out_grant holds exactly one bit until in_done of that index is 1, then returns to ARB on the next edge with out_grant=0 for at least one cycle.
REQ-019 A completed grant increments out_served, saturating at 255; out_served clears on window open.
REQ-020 Withdrawal of the granted in_req without in_done is treated as in_done (release; counts as served).
REQ-021 in_done from a non-granted index, or outside GRANT, is ignored.
REQ-022 in_strobe&in_scrend in ARB or GRANT -> DRAIN; out_grant clears and out_window falls on the same edge.
REQ-023 out_overrun sets on the REQ-022 edge if in GRANT, or if any in_req bit is set; it clears only on reset.
REQ-024 DRAIN->IDLE on the next edge unconditionally.
REQ-025 in_anim arriving outside IDLE is ignored; in_scrend in IDLE is ignored.
REQ-026 Simultaneous in_done and in_scrend in GRANT: the release counts as served and no overrun is raised for that requester; REQ-022 applies otherwise.
REQ-027 out_grant never has more than one bit set; it is never nonzero outside GRANT.

Reset
REQ-028 While in_reset_n=0: state IDLE, out_grant=0, out_window=0, out_overrun=0, out_served=0, RR pointer=N_REQ-1, hold counter=0.
REQ-029 Reset asserted mid-grant revokes the grant immediately (asynchronously) with no served count.
REQ-030 After deassertion, the first window opens only on a fresh in_strobe&in_anim.

Configuration
REQ-031 Macro BLANK_ARB_TIMEOUT_EN defined: the hold counter counts clock cycles in GRANT; after MAX_HOLD cycles the grant is force-released (not counted as served), RR advances, and out_timeout (1-bit output, one-cycle pulse) asserts.
REQ-032 Macro not defined: no hold counter and no out_timeout port; a grant persists until in_done, request withdrawal or window close.

Structure
REQ-033 Package blank_arb_pkg holds the FSM state enum, default N_REQ, MAX_HOLD, and the served-counter width.
REQ-034 Sub-module rr_picker: combinational round-robin one-hot selector (inputs request vector and pointer; outputs grant and valid).

Verification
REQ-035 Reset, then in_req=4'b1111 and anim tick -> grants 0,1,2,3 in order, each released by in_done; out_served=4.
REQ-036 in_req=4'b0100 with the last grant at 3 -> grant 4'b0100 on the edge after ARB; no bubble longer than 1 cycle.
REQ-037 Grant held at index 1 when in_strobe&in_scrend -> out_grant=0 and out_window=0 on that edge; out_overrun=1 and stays 1 through the next frame.
REQ-038 in_done on index 2 while index 1 is granted -> no change; grant stays 4'b0010.
REQ-039 With BLANK_ARB_TIMEOUT_EN and MAX_HOLD=16, grant 0 with no in_done -> release after 16 cycles; out_timeout pulses for 1 cycle; next grant goes to index 1; out_served unchanged.
REQ-040 in_reset_n pulsed low during GRANT -> all outputs 0 immediately; no grant until the next anim tick.
